// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select and load-use stall control for the EX stage.
// Drives EX operand muxes, PC/IF-ID write enables, bubble insert, stall stats.
//
// Ports:
//   Clk, Rst_n          clock (rising), async active-low reset
//   EXMEMRegWrite/Rd    EX/MEM writeback intent and destination
//   MEMWBRegWrite/Rd    MEM/WB writeback intent and destination
//   IDEXRs/Rt           EX-stage sources (Rt is also the load destination)
//   IDEXMemRead         EX-stage instruction is a load
//   IFIDRs/Rt           ID-stage sources; IFIDUsesRt qualifies Rt
//   Flush               IF/ID squashed by a taken branch/jump
//   Amux/Bmux           00 regfile, 01 EX/MEM, 10 MEM/WB, 11 history
//   PCWrite, IFIDWrite  front-end write enables (low while stalled)
//   IDEXBubble          insert NOP into ID/EX
//   StallCount          saturating count of stalled cycles since reset
module fwd_hazard_unit #(
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            EXMEMRegWrite,
  input  logic [RA_W-1:0] EXMEMRd,
  input  logic            MEMWBRegWrite,
  input  logic [RA_W-1:0] MEMWBRd,
  input  logic [RA_W-1:0] IDEXRs,
  input  logic [RA_W-1:0] IDEXRt,
  input  logic            IDEXMemRead,
  input  logic [RA_W-1:0] IFIDRs,
  input  logic [RA_W-1:0] IFIDRt,
  input  logic            IFIDUsesRt,
  input  logic            Flush,
  output logic [1:0]      Amux,
  output logic [1:0]      Bmux,
  output logic            PCWrite,
  output logic            IFIDWrite,
  output logic            IDEXBubble,
  output logic [CNT_W-1:0] StallCount
);

  localparam int LC_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  typedef enum logic {
    IDLE,
    STALL
  } state_e;

  state_e            state_q, state_d;
  logic [LC_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic              hist_valid_q, hist_valid_d;
  logic [RA_W-1:0]   hist_rd_q, hist_rd_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              hazard;
  logic              stall_raw;
  logic              stall;

  // The history entry is only valid for a nonzero destination; the
  // explicit src check keeps r0 out of every forwarding path.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (EXMEMRegWrite && EXMEMRd == src)
        sel = 2'b01;
      else if (MEMWBRegWrite && MEMWBRd == src)
        sel = 2'b10;
      else if (hist_valid_q && hist_rd_q == src)
        sel = 2'b11;
    end
    return sel;
  endfunction

  always_comb begin
    Amux = fwd_sel(IDEXRs);
    Bmux = fwd_sel(IDEXRt);
  end

  always_comb begin
    hist_valid_d = MEMWBRegWrite && (MEMWBRd != '0);
    hist_rd_d    = MEMWBRd;
  end

  assign hazard = IDEXMemRead && (IDEXRt != '0) && !Flush &&
                  ((IDEXRt == IFIDRs) ||
                   (IFIDUsesRt && IDEXRt == IFIDRt));

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    stall_raw = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hazard) begin
          stall_raw = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d   = STALL;
            lat_cnt_d = LC_W'(LOAD_LAT - 1);
          end
        end
      end
      STALL: begin
        // The dependent instruction is gone, so the hold is pointless.
        if (Flush) begin
          state_d   = IDLE;
          lat_cnt_d = '0;
        end else begin
          stall_raw = 1'b1;
          lat_cnt_d = lat_cnt_q - LC_W'(1);
          if (lat_cnt_q == LC_W'(1))
            state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        lat_cnt_d = '0;
      end
    endcase
  end

  // Gate with reset so the front end runs freely while reset is held,
  // even if a hazard pattern sits on the inputs.
  assign stall      = stall_raw && Rst_n;
  assign PCWrite    = !stall;
  assign IFIDWrite  = !stall;
  assign IDEXBubble = stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  assign StallCount = stall_cnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      hist_valid_q <= 1'b0;
      hist_rd_q    <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      hist_valid_q <= hist_valid_d;
      hist_rd_q    <= hist_rd_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: three instances (LOAD_LAT 1/3/4)
// share one stimulus set; the LOAD_LAT=4 copy uses a 4-bit StallCount.
module tb_fwd_hazard_unit;

  logic       clk;
  logic       rst_n;
  logic       exmem_wr, memwb_wr, idex_mr, usesrt, flush;
  logic [4:0] exmem_rd, memwb_rd, idex_rs, idex_rt, ifid_rs, ifid_rt;

  logic [1:0]  a1, b1, a3, b3, a4, b4;
  logic        pcw1, ifw1, bub1;
  logic        pcw3, ifw3, bub3;
  logic        pcw4, ifw4, bub4;
  logic [15:0] sc1, sc3;
  logic [3:0]  sc4;

  int vec;
  int miss;

  fwd_hazard_unit #(.RA_W(5), .LOAD_LAT(1), .CNT_W(16)) d1 (
    .Clk(clk), .Rst_n(rst_n),
    .EXMEMRegWrite(exmem_wr), .EXMEMRd(exmem_rd),
    .MEMWBRegWrite(memwb_wr), .MEMWBRd(memwb_rd),
    .IDEXRs(idex_rs), .IDEXRt(idex_rt), .IDEXMemRead(idex_mr),
    .IFIDRs(ifid_rs), .IFIDRt(ifid_rt), .IFIDUsesRt(usesrt),
    .Flush(flush), .Amux(a1), .Bmux(b1),
    .PCWrite(pcw1), .IFIDWrite(ifw1), .IDEXBubble(bub1),
    .StallCount(sc1)
  );

  fwd_hazard_unit #(.RA_W(5), .LOAD_LAT(3), .CNT_W(16)) d3 (
    .Clk(clk), .Rst_n(rst_n),
    .EXMEMRegWrite(exmem_wr), .EXMEMRd(exmem_rd),
    .MEMWBRegWrite(memwb_wr), .MEMWBRd(memwb_rd),
    .IDEXRs(idex_rs), .IDEXRt(idex_rt), .IDEXMemRead(idex_mr),
    .IFIDRs(ifid_rs), .IFIDRt(ifid_rt), .IFIDUsesRt(usesrt),
    .Flush(flush), .Amux(a3), .Bmux(b3),
    .PCWrite(pcw3), .IFIDWrite(ifw3), .IDEXBubble(bub3),
    .StallCount(sc3)
  );

  fwd_hazard_unit #(.RA_W(5), .LOAD_LAT(4), .CNT_W(4)) d4 (
    .Clk(clk), .Rst_n(rst_n),
    .EXMEMRegWrite(exmem_wr), .EXMEMRd(exmem_rd),
    .MEMWBRegWrite(memwb_wr), .MEMWBRd(memwb_rd),
    .IDEXRs(idex_rs), .IDEXRt(idex_rt), .IDEXMemRead(idex_mr),
    .IFIDRs(ifid_rs), .IFIDRt(ifid_rt), .IFIDUsesRt(usesrt),
    .Flush(flush), .Amux(a4), .Bmux(b4),
    .PCWrite(pcw4), .IFIDWrite(ifw4), .IDEXBubble(bub4),
    .StallCount(sc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_in();
    exmem_wr = 0; memwb_wr = 0; idex_mr = 0;
    usesrt = 0; flush = 0;
    exmem_rd = 0; memwb_rd = 0; idex_rs = 0;
    idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
  endtask

  task automatic set_hazard();
    idex_mr = 1; idex_rt = 5'd4; ifid_rs = 5'd4;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_in();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_in();
    set_hazard();
    #1;
    vec++;
    if (pcw1 !== 1'b1 || ifw1 !== 1'b1 || bub1 !== 1'b0) begin
      miss++;
      $display("FAIL reset_outs: pcw=%0b ifw=%0b bub=%0b want 1 1 0",
               pcw1, ifw1, bub1);
    end
    vec++;
    if (sc1 !== 16'd0 || sc3 !== 16'd0 || sc4 !== 4'd0) begin
      miss++;
      $display("FAIL reset_cnt: sc1=%0d sc3=%0d sc4=%0d want 0",
               sc1, sc3, sc4);
    end
    @(negedge clk);
    idle_in();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_fwd_priority();
    @(negedge clk);
    exmem_wr = 1; exmem_rd = 5'd8;
    memwb_wr = 1; memwb_rd = 5'd8;
    idex_rs = 5'd8; idex_rt = 5'd9;
    #1;
    vec++;
    if (a1 !== 2'b01 || b1 !== 2'b00) begin
      miss++;
      $display("FAIL fwd_both: a=%b b=%b want 01 00", a1, b1);
    end
    @(negedge clk);
    exmem_wr = 0;
    #1;
    vec++;
    if (a1 !== 2'b10) begin
      miss++;
      $display("FAIL fwd_memwb: a=%b want 10", a1);
    end
    @(negedge clk);
    exmem_wr = 1; exmem_rd = 5'd9;
    memwb_wr = 0; idex_rs = 5'd3; idex_rt = 5'd9;
    #1;
    vec++;
    if (a1 !== 2'b00 || b1 !== 2'b01) begin
      miss++;
      $display("FAIL fwd_b_exmem: a=%b b=%b want 00 01", a1, b1);
    end
    @(negedge clk);
    exmem_wr = 1; exmem_rd = 0;
    memwb_wr = 1; memwb_rd = 0;
    idex_rs = 0; idex_rt = 0;
    #1;
    vec++;
    if (a1 !== 2'b00 || b1 !== 2'b00) begin
      miss++;
      $display("FAIL fwd_r0: a=%b b=%b want 00 00", a1, b1);
    end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_history();
    @(negedge clk);
    idle_in();
    memwb_wr = 1; memwb_rd = 5'd5; idex_rt = 5'd5;
    #1;
    vec++;
    if (b1 !== 2'b10) begin
      miss++;
      $display("FAIL hist_pre: b=%b want 10", b1);
    end
    @(negedge clk);
    memwb_wr = 0; idex_rs = 5'd5;
    #1;
    vec++;
    if (b1 !== 2'b11 || a1 !== 2'b11) begin
      miss++;
      $display("FAIL hist_hit: a=%b b=%b want 11 11", a1, b1);
    end
    @(negedge clk);
    #1;
    vec++;
    if (b1 !== 2'b00) begin
      miss++;
      $display("FAIL hist_expire: b=%b want 00", b1);
    end
    @(negedge clk);
    idle_in();
    memwb_wr = 1; memwb_rd = 5'd0;
    @(negedge clk);
    memwb_wr = 0;
    #1;
    vec++;
    if (b1 !== 2'b00 || a1 !== 2'b00) begin
      miss++;
      $display("FAIL hist_r0: a=%b b=%b want 00 00", a1, b1);
    end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_load_lat1();
    do_reset();
    @(negedge clk);
    set_hazard();
    #1;
    vec++;
    if (pcw1 !== 1'b0 || ifw1 !== 1'b0 || bub1 !== 1'b1) begin
      miss++;
      $display("FAIL l1_stall: pcw=%0b ifw=%0b bub=%0b want 0 0 1",
               pcw1, ifw1, bub1);
    end
    vec++;
    if (sc1 !== 16'd0) begin
      miss++;
      $display("FAIL l1_cnt0: sc=%0d want 0", sc1);
    end
    @(negedge clk);
    idle_in();
    #1;
    vec++;
    if (pcw1 !== 1'b1 || bub1 !== 1'b0 || sc1 !== 16'd1) begin
      miss++;
      $display("FAIL l1_release: pcw=%0b bub=%0b sc=%0d want 1 0 1",
               pcw1, bub1, sc1);
    end
  endtask

  task automatic test_load_lat3();
    do_reset();
    @(negedge clk);
    set_hazard();
    #1;
    vec++;
    if (pcw3 !== 1'b0 || bub3 !== 1'b1) begin
      miss++;
      $display("FAIL l3_c1: pcw=%0b bub=%0b want 0 1", pcw3, bub3);
    end
    @(negedge clk);
    idle_in();
    for (int c = 2; c <= 3; c++) begin
      #1;
      vec++;
      if (pcw3 !== 1'b0 || ifw3 !== 1'b0 || bub3 !== 1'b1) begin
        miss++;
        $display("FAIL l3_c%0d: pcw=%0b ifw=%0b bub=%0b want 0 0 1",
                 c, pcw3, ifw3, bub3);
      end
      @(negedge clk);
    end
    #1;
    vec++;
    if (pcw3 !== 1'b1 || sc3 !== 16'd3 || sc1 !== 16'd1) begin
      miss++;
      $display("FAIL l3_end: pcw=%0b sc3=%0d sc1=%0d want 1 3 1",
               pcw3, sc3, sc1);
    end
    @(negedge clk);
    idex_mr = 1; idex_rt = 5'd4; ifid_rs = 5'd7;
    ifid_rt = 5'd4; usesrt = 0;
    #1;
    vec++;
    if (pcw3 !== 1'b1 || pcw1 !== 1'b1) begin
      miss++;
      $display("FAIL l3_nouse: pcw3=%0b pcw1=%0b want 1 1", pcw3, pcw1);
    end
    idex_rt = 0; ifid_rs = 0; ifid_rt = 0; usesrt = 1;
    #1;
    vec++;
    if (pcw1 !== 1'b1) begin
      miss++;
      $display("FAIL l3_r0load: pcw=%0b want 1", pcw1);
    end
    idex_rt = 5'd4; ifid_rt = 5'd4;
    #1;
    vec++;
    if (pcw1 !== 1'b0) begin
      miss++;
      $display("FAIL l3_usesrt: pcw=%0b want 0", pcw1);
    end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk);
    set_hazard();
    flush = 1;
    #1;
    vec++;
    if (pcw1 !== 1'b1 || pcw3 !== 1'b1) begin
      miss++;
      $display("FAIL fl_idle: pcw1=%0b pcw3=%0b want 1 1", pcw1, pcw3);
    end
    flush = 0;
    #1;
    vec++;
    if (pcw3 !== 1'b0) begin
      miss++;
      $display("FAIL fl_c1: pcw=%0b want 0", pcw3);
    end
    @(negedge clk);
    idle_in();
    flush = 1;
    #1;
    vec++;
    if (pcw3 !== 1'b1 || bub3 !== 1'b0 || sc3 !== 16'd1) begin
      miss++;
      $display("FAIL fl_c2: pcw=%0b bub=%0b sc=%0d want 1 0 1",
               pcw3, bub3, sc3);
    end
    @(negedge clk);
    flush = 0;
    #1;
    vec++;
    if (pcw3 !== 1'b1 || sc3 !== 16'd1) begin
      miss++;
      $display("FAIL fl_after: pcw=%0b sc=%0d want 1 1", pcw3, sc3);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    set_hazard();
    @(negedge clk);
    idle_in();
    #1;
    vec++;
    if (pcw4 !== 1'b0 || sc4 !== 4'd1) begin
      miss++;
      $display("FAIL ar_mid: pcw=%0b sc=%0d want 0 1", pcw4, sc4);
    end
    #1;
    rst_n = 0;
    #1;
    vec++;
    if (pcw4 !== 1'b1 || bub4 !== 1'b0 || sc4 !== 4'd0) begin
      miss++;
      $display("FAIL ar_rel: pcw=%0b bub=%0b sc=%0d want 1 0 0",
               pcw4, bub4, sc4);
    end
    #1;
    rst_n = 1;
    @(negedge clk);
    #1;
    vec++;
    if (pcw4 !== 1'b1 || sc4 !== 4'd0) begin
      miss++;
      $display("FAIL ar_idle: pcw=%0b sc=%0d want 1 0", pcw4, sc4);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    @(negedge clk);
    set_hazard();
    repeat (20) @(negedge clk);
    #1;
    vec++;
    if (sc4 !== 4'd15) begin
      miss++;
      $display("FAIL sat4: sc=%0d want 15", sc4);
    end
    vec++;
    if (sc1 !== 16'd20 || sc3 !== 16'd20) begin
      miss++;
      $display("FAIL sat_wide: sc1=%0d sc3=%0d want 20 20", sc1, sc3);
    end
    idle_in();
  endtask

  initial begin
    vec = 0;
    miss = 0;
    test_reset();
    test_fwd_priority();
    test_history();
    test_load_lat1();
    test_load_lat3();
    test_flush();
    test_async_reset();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
